// File: rtl/sha1_padder.sv
// SHA-1 message padder: packs 32-bit big-endian words into 512-bit blocks, appends the
// 0x80 marker, zero fill and the 64-bit message bit-length, and flags the final block.
module sha1_padder #(
  parameter int BlockWidth = 512,
  parameter int WordWidth  = 32,
  parameter int LenWidth   = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic [WordWidth-1:0]  data_i,
  input  logic [2:0]            bytes_i,
  input  logic                  last_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [BlockWidth-1:0] block_o,
  output logic                  last_block_o,
  output logic                  block_valid_o,
  input  logic                  block_ready_i
);

  typedef enum logic [1:0] {FILL, EMIT, EXTRA} state_t;

  state_t                state;
  logic [3:0]            word_cnt;
  logic [LenWidth-1:0]   len;
  logic                  pend_extra;
  logic                  extra_80;
  logic [2:0]            n;
  logic [6:0]            p;
  logic [LenWidth-1:0]   len_nxt;
  logic [BlockWidth-1:0] pad_blk;

  // Bytes before the current slot are kept, the n valid bytes copied, 0x80 placed at
  // byte p and everything after it zeroed. For non-final words the tail is scratch
  // that later words overwrite.
  function automatic logic [BlockWidth-1:0] pad_word(input logic [BlockWidth-1:0] blk,
                                                     input logic [3:0]            wc,
                                                     input logic [WordWidth-1:0]  data,
                                                     input logic [6:0]            pos);
    logic [BlockWidth-1:0] r;
    int base;
    int pi;
    int j;
    r    = blk;
    base = 4 * int'(wc);
    pi   = int'(pos);
    for (int i = 0; i < BlockWidth / 8; i++) begin
      if (i >= base) begin
        j = i - base;
        if (i < pi)
          r[BlockWidth-1-8*i -: 8] = data[WordWidth-1-8*j -: 8];
        else if (i == pi)
          r[BlockWidth-1-8*i -: 8] = 8'h80;
        else
          r[BlockWidth-1-8*i -: 8] = 8'h00;
      end
    end
    return r;
  endfunction

  assign n       = last_i ? bytes_i : 3'd4;
  assign p       = {1'b0, word_cnt, 2'b00} + {4'b0000, n};
  assign len_nxt = len + LenWidth'({n, 3'b000});
  assign pad_blk = pad_word(block_o, word_cnt, data_i, p);
  assign ready_o = (state == FILL);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= FILL;
      word_cnt      <= 4'd0;
      len           <= '0;
      block_o       <= '0;
      block_valid_o <= 1'b0;
      last_block_o  <= 1'b0;
      pend_extra    <= 1'b0;
      extra_80      <= 1'b0;
    end else if (clear_i) begin
      state         <= FILL;
      word_cnt      <= 4'd0;
      len           <= '0;
      block_o       <= '0;
      block_valid_o <= 1'b0;
      last_block_o  <= 1'b0;
      pend_extra    <= 1'b0;
      extra_80      <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (valid_i) begin
            block_o  <= pad_blk;
            word_cnt <= word_cnt + 4'd1;
            len      <= len_nxt;
            if (last_i) begin
              // Length fits in this block only if bytes 56..63 are still free.
              if (p <= 7'd55) begin
                block_o      <= {pad_blk[BlockWidth-1:LenWidth], len_nxt};
                last_block_o <= 1'b1;
              end else begin
                pend_extra   <= 1'b1;
                extra_80     <= (p == 7'd64);
                last_block_o <= 1'b0;
              end
              state         <= EMIT;
              block_valid_o <= 1'b1;
            end else if (word_cnt == 4'd15) begin
              state         <= EMIT;
              block_valid_o <= 1'b1;
              last_block_o  <= 1'b0;
            end
          end
        end
        EMIT: begin
          if (block_ready_i) begin
            block_valid_o <= 1'b0;
            if (last_block_o) begin
              state        <= FILL;
              word_cnt     <= 4'd0;
              len          <= '0;
              block_o      <= '0;
              last_block_o <= 1'b0;
            end else if (pend_extra) begin
              state <= EXTRA;
            end else begin
              state    <= FILL;
              word_cnt <= 4'd0;
            end
          end
        end
        EXTRA: begin
          block_o       <= {(extra_80 ? 8'h80 : 8'h00), {(BlockWidth-8-LenWidth){1'b0}}, len};
          last_block_o  <= 1'b1;
          pend_extra    <= 1'b0;
          block_valid_o <= 1'b1;
          state         <= EMIT;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_padder.sv
// Bench for sha1_padder: reference FIPS padding model feeds a scoreboard of expected blocks
// that a randomly-stalling consumer pops and compares.
module tb_sha1_padder;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         clear_i;
  logic [31:0]  data_i;
  logic [2:0]   bytes_i;
  logic         last_i;
  logic         valid_i;
  logic         ready_o;
  logic [511:0] block_o;
  logic         last_block_o;
  logic         block_valid_o;
  logic         block_ready_i;

  sha1_padder dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .data_i       (data_i),
    .bytes_i      (bytes_i),
    .last_i       (last_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .block_o      (block_o),
    .last_block_o (last_block_o),
    .block_valid_o(block_valid_o),
    .block_ready_i(block_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [511:0] blk;
    logic         last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   rx_blocks = 0;
  bit   stall = 1'b1;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference padding: 0x80, zeros to 56 mod 64, big-endian 64-bit bit count.
  task automatic push_expected(input logic [7:0] msg[$]);
    logic [7:0]  pad[$];
    logic [63:0] bitlen;
    exp_t        e;
    int          nb;
    pad = msg;
    pad.push_back(8'h80);
    while (pad.size() % 64 != 56) pad.push_back(8'h00);
    bitlen = 64'(msg.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) pad.push_back(bitlen[8*k +: 8]);
    nb = pad.size() / 64;
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < 64; i++) e.blk[511-8*i -: 8] = pad[64*b+i];
      e.last = (b == nb - 1);
      exp_q.push_back(e);
      pushed++;
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input logic lst);
    int t;
    valid_i = 1'b1;
    data_i  = d;
    bytes_i = nb;
    last_i  = lst;
    t = 0;
    while (!ready_o) begin
      @(negedge clk_i);
      t++;
      if (t > 500) begin
        check("ready_timeout", 512'(ready_o), 512'd1);
        break;
      end
    end
    @(negedge clk_i);
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic send_msg(input logic [7:0] msg[$]);
    int          len;
    int          nw;
    logic [31:0] w;
    logic        lst;
    push_expected(msg);
    len = msg.size();
    nw  = (len == 0) ? 1 : (len + 3) / 4;
    for (int wi = 0; wi < nw; wi++) begin
      w = $urandom;
      for (int k = 0; k < 4; k++)
        if (4*wi + k < len) w[31-8*k -: 8] = msg[4*wi+k];
      lst = (wi == nw - 1);
      send_word(w, lst ? 3'(len - 4*wi) : 3'd4, lst);
    end
  endtask

  task automatic rand_msg(input int len);
    logic [7:0] m[$];
    for (int i = 0; i < len; i++) m.push_back(8'($urandom));
    send_msg(m);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk_i);
      t++;
    end
    check("drain", 512'(exp_q.size()), 512'd0);
  endtask

  // Consumer: ready is chosen first on the falling edge, so valid&ready seen here is
  // exactly the transfer that happens on the following rising edge.
  initial begin
    exp_t e;
    block_ready_i = 1'b0;
    forever begin
      @(negedge clk_i);
      block_ready_i = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (block_valid_o && block_ready_i && rst_ni && !clear_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_block", 512'(exp_q.size()), 512'd1);
        end else begin
          e = exp_q.pop_front();
          check("block", block_o, e.blk);
          check("last_block", 512'(last_block_o), 512'(e.last));
          rx_blocks++;
        end
      end
    end
  end

  initial begin
    logic [7:0]   abc[$];
    logic [511:0] held;
    abc = '{8'h61, 8'h62, 8'h63};
    rst_ni  = 1'b0;
    clear_i = 1'b0;
    valid_i = 1'b0;
    last_i  = 1'b0;
    data_i  = '0;
    bytes_i = 3'd0;
    repeat (3) @(negedge clk_i);
    check("rst_ready", 512'(ready_o), 512'd1);
    check("rst_valid", 512'(block_valid_o), 512'd0);
    check("rst_last", 512'(last_block_o), 512'd0);
    check("rst_block", block_o, 512'd0);
    rst_ni = 1'b1;
    stall  = 1'b0;
    @(negedge clk_i);

    send_msg(abc);
    rand_msg(0);
    rand_msg(55);
    rand_msg(56);
    rand_msg(64);
    rand_msg(61);
    rand_msg(100);
    rand_msg(128);
    rand_msg(119);
    rand_msg(120);
    wait_drain();

    // Backpressure: block must hold and no input accepted.
    stall = 1'b1;
    push_expected(abc);
    send_word(32'h61626355, 3'd3, 1'b1);
    held = block_o;
    check("bp_valid_rise", 512'(block_valid_o), 512'd1);
    for (int c = 0; c < 10; c++) begin
      valid_i = 1'b1;
      data_i  = 32'hDEADBEEF;
      bytes_i = 3'd4;
      @(negedge clk_i);
      check("bp_stable", block_o, held);
      check("bp_ready", 512'(ready_o), 512'd0);
      check("bp_valid", 512'(block_valid_o), 512'd1);
    end
    valid_i = 1'b0;
    stall   = 1'b0;
    wait_drain();

    // Abort after five words, with a word offered on the clear edge.
    for (int i = 0; i < 5; i++) send_word($urandom, 3'd4, 1'b0);
    clear_i = 1'b1;
    valid_i = 1'b1;
    data_i  = 32'h12345678;
    bytes_i = 3'd4;
    @(negedge clk_i);
    clear_i = 1'b0;
    valid_i = 1'b0;
    check("clr_valid", 512'(block_valid_o), 512'd0);
    check("clr_ready", 512'(ready_o), 512'd1);
    send_msg(abc);
    wait_drain();

    // Asynchronous reset mid-message.
    for (int i = 0; i < 3; i++) send_word($urandom, 3'd4, 1'b0);
    #2 rst_ni = 1'b0;
    #1 check("arst_block", block_o, 512'd0);
    check("arst_ready", 512'(ready_o), 512'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    send_msg(abc);
    rand_msg(57);
    wait_drain();

    check("block_count", 512'(rx_blocks), 512'(pushed));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
